// File: rtl/rtc_bus_controller.sv
// Sequences one read or write on the RTC's multiplexed 8-bit address/data bus.
// Each bus phase is stretched to T_PHASE clocks; all outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | bus released, waiting for start
// ADDR_SET  | address driven, cs_n low, strobe high (setup)
// ADDR_STB  | wr_n low latches the address
// ADDR_HOLD | address held after the strobe
// DATA_SET  | write byte driven (setup)
// DATA_STB  | wr_n low writes the byte
// DATA_HOLD | write byte held after the strobe
// TURN      | buffer released, AD turnaround before read
// RD_STB    | rd_n low, RTC drives AD; captured on last cycle
// RD_HOLD   | rd_n high again, cs_n still low
// RELEASE   | cs_n high, bus idle
// DONE      | one-clock done pulse
module rtc_bus_controller #(
   parameter int T_PHASE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] sig_out,
   input  logic [7:0] sig_in,
   output logic       buffer_activo,
   output logic       cs_n,
   output logic       a_d_n,
   output logic       wr_n,
   output logic       rd_n
);

   localparam int CW = $clog2(T_PHASE + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(T_PHASE - 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR_SET  = 4'd1;
   localparam logic [3:0] S_ADDR_STB  = 4'd2;
   localparam logic [3:0] S_ADDR_HOLD = 4'd3;
   localparam logic [3:0] S_DATA_SET  = 4'd4;
   localparam logic [3:0] S_DATA_STB  = 4'd5;
   localparam logic [3:0] S_DATA_HOLD = 4'd6;
   localparam logic [3:0] S_TURN      = 4'd7;
   localparam logic [3:0] S_RD_STB    = 4'd8;
   localparam logic [3:0] S_RD_HOLD   = 4'd9;
   localparam logic [3:0] S_RELEASE   = 4'd10;
   localparam logic [3:0] S_DONE      = 4'd11;

   logic [3:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          rw_q;
   logic [7:0]    addr_q, wdata_q;
   logic          phase_end;
   logic [7:0]    addr_sel;
   logic          cs_n_n, a_d_n_n, wr_n_n, rd_n_n, buf_n;
   logic [7:0]    sig_out_n;

   assign phase_end = (cnt == '0);
   // ADDR_SET is entered on the same edge that latches addr, so use the live input then
   assign addr_sel  = (state == S_IDLE) ? addr : addr_q;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (start)     state_n = S_ADDR_SET;
         S_ADDR_SET:  if (phase_end) state_n = S_ADDR_STB;
         S_ADDR_STB:  if (phase_end) state_n = S_ADDR_HOLD;
         S_ADDR_HOLD: if (phase_end) state_n = rw_q ? S_TURN : S_DATA_SET;
         S_DATA_SET:  if (phase_end) state_n = S_DATA_STB;
         S_DATA_STB:  if (phase_end) state_n = S_DATA_HOLD;
         S_DATA_HOLD: if (phase_end) state_n = S_RELEASE;
         S_TURN:      if (phase_end) state_n = S_RD_STB;
         S_RD_STB:    if (phase_end) state_n = S_RD_HOLD;
         S_RD_HOLD:   if (phase_end) state_n = S_RELEASE;
         S_RELEASE:   if (phase_end) state_n = S_DONE;
         S_DONE:                     state_n = S_IDLE;
         default:                    state_n = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_n = cnt;
      if (state_n == S_IDLE || state_n == S_DONE) cnt_n = '0;
      else if (state_n != state)                  cnt_n = CNT_LOAD;
      else if (!phase_end)                        cnt_n = cnt - CW'(1);
   end

   always_comb begin
      cs_n_n    = 1'b1;
      a_d_n_n   = 1'b1;
      wr_n_n    = 1'b1;
      rd_n_n    = 1'b1;
      buf_n     = 1'b0;
      sig_out_n = 8'h00;
      case (state_n)
         S_ADDR_SET, S_ADDR_STB, S_ADDR_HOLD: begin
            cs_n_n    = 1'b0;
            a_d_n_n   = 1'b0;
            buf_n     = 1'b1;
            sig_out_n = addr_sel;
            wr_n_n    = (state_n != S_ADDR_STB);
         end
         S_DATA_SET, S_DATA_STB, S_DATA_HOLD: begin
            cs_n_n    = 1'b0;
            buf_n     = 1'b1;
            sig_out_n = wdata_q;
            wr_n_n    = (state_n != S_DATA_STB);
         end
         S_TURN, S_RD_STB, S_RD_HOLD: begin
            cs_n_n    = 1'b0;
            rd_n_n    = (state_n != S_RD_STB);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         rw_q          <= 1'b0;
         addr_q        <= 8'h00;
         wdata_q       <= 8'h00;
         rdata         <= 8'h00;
         busy          <= 1'b0;
         done          <= 1'b0;
         sig_out       <= 8'h00;
         buffer_activo <= 1'b0;
         cs_n          <= 1'b1;
         a_d_n         <= 1'b1;
         wr_n          <= 1'b1;
         rd_n          <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == S_IDLE && start) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state == S_RD_STB && phase_end) rdata <= sig_in;
         busy          <= (state_n != S_IDLE);
         done          <= (state_n == S_DONE);
         sig_out       <= sig_out_n;
         buffer_activo <= buf_n;
         cs_n          <= cs_n_n;
         a_d_n         <= a_d_n_n;
         wr_n          <= wr_n_n;
         rd_n          <= rd_n_n;
      end
   end

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Self-checking bench for rtc_bus_controller: a per-cycle schedule model for T_PHASE=4
// plus a T_PHASE=1 instance for single-clock phases and back-to-back starts.
module tb_rtc_bus_controller;

   localparam int TP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, rw;
   logic [7:0] addr, wdata;
   logic [7:0] rdata, sig_out, sig_in;
   logic       busy, done, buffer_activo, cs_n, a_d_n, wr_n, rd_n;

   logic       start1, rw1;
   logic [7:0] addr1, wdata1;
   logic [7:0] rdata1, sig_out1, sig_in1;
   logic       busy1, done1, buffer_activo1, cs_n1, a_d_n1, wr_n1, rd_n1;

   logic [7:0]  rtc_byte;
   logic [7:0]  exp_rdata;
   logic [22:0] obs;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // RTC model: drives its register byte only while rd_n is low
   assign sig_in  = rd_n  ? 8'hEE : rtc_byte;
   assign sig_in1 = rd_n1 ? 8'hEE : 8'h3C;
   assign obs = {cs_n, a_d_n, wr_n, rd_n, buffer_activo, busy, done, sig_out, rdata};

   rtc_bus_controller #(.T_PHASE(TP)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .sig_out(sig_out), .sig_in(sig_in),
      .buffer_activo(buffer_activo), .cs_n(cs_n), .a_d_n(a_d_n), .wr_n(wr_n), .rd_n(rd_n));

   rtc_bus_controller #(.T_PHASE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
      .rdata(rdata1), .busy(busy1), .done(done1), .sig_out(sig_out1), .sig_in(sig_in1),
      .buffer_activo(buffer_activo1), .cs_n(cs_n1), .a_d_n(a_d_n1), .wr_n(wr_n1), .rd_n(rd_n1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected outputs in cycle k+j after the accepting edge k (j=0 means idle).
   // Seven phases of TP clocks: addr x3, data-or-read x3, release; then one DONE clock.
   function automatic logic [22:0] expv(int j, logic rwv, logic [7:0] a, logic [7:0] w,
                                        logic [7:0] rx);
      logic cs, ad, wr, rd, bf, bs, dn;
      logic [7:0] so;
      int p;
      cs = 1'b1; ad = 1'b1; wr = 1'b1; rd = 1'b1; bf = 1'b0; so = 8'h00;
      bs = (j != 0);
      dn = 1'b0;
      if (j == 7*TP + 1) dn = 1'b1;
      else if (j >= 1) begin
         p = (j - 1) / TP;
         if (p <= 2) begin
            cs = 1'b0; ad = 1'b0; bf = 1'b1; so = a; wr = (p != 1);
         end else if (p <= 5) begin
            cs = 1'b0;
            if (!rwv) begin
               bf = 1'b1; so = w; wr = (p != 4);
            end else
               rd = (p != 4);
         end
      end
      return {cs, ad, wr, rd, bf, bs, dn, so, rx};
   endfunction

   task automatic check_vec(string tag, logic [22:0] expected);
      checks++;
      assert (obs === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expected);
      end
   endtask

   task automatic run_txn(input logic rwv, input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] rb, input bit spam, input string tag);
      rtc_byte = rb;
      rw = rwv; addr = a; wdata = w; start = 1'b1;
      tick;
      for (int j = 1; j <= 7*TP + 1; j++) begin
         if (rwv && j == 5*TP + 1) exp_rdata = rb;
         check_vec(tag, expv(j, rwv, a, w, exp_rdata));
         checks++;
         assert (!(buffer_activo && !rd_n) && !(!wr_n && !rd_n)) else begin
            failures++;
            $error("FAIL %s_overlap cycle=%0d buf=%b wr_n=%b rd_n=%b expected no overlap",
                   tag, j, buffer_activo, wr_n, rd_n);
         end
         if (spam) begin
            start = 1'($urandom);
            rw    = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
         end else
            start = 1'b0;
         tick;
      end
      start = 1'b0;
      check_vec({tag, "_idle"}, expv(0, rwv, a, w, exp_rdata));
   endtask

   initial begin
      logic [7:0] ra, rwd, rbv;
      int n;

      reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; rtc_byte = 8'h00;
      start1 = 1'b0; rw1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
      exp_rdata = 8'h00;
      repeat (3) tick;
      check_vec("reset", expv(0, 1'b0, 8'h00, 8'h00, 8'h00));
      reset = 1'b0;
      tick;
      check_vec("after_reset", expv(0, 1'b0, 8'h00, 8'h00, 8'h00));

      run_txn(1'b0, 8'h21, 8'h59, 8'h00, 1'b0, "write_21_59");
      run_txn(1'b1, 8'h22, 8'h00, 8'h47, 1'b0, "read_22");
      checks++;
      assert (rdata === 8'h47) else begin
         failures++;
         $error("FAIL read_22_rdata observed=%h expected=47", rdata);
      end
      run_txn(1'b0, 8'hA5, 8'h3C, 8'h00, 1'b1, "write_spam");
      tick;

      // back-to-back random transactions with start spam while busy
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom); rwd = 8'($urandom); rbv = 8'($urandom);
         if (rbv == 8'hEE) rbv = 8'h11;
         run_txn(1'($urandom), ra, rwd, rbv, bit'($urandom), "random");
      end

      // reset while RD_STB is active
      rtc_byte = 8'h5A; rw = 1'b1; addr = 8'h30; start = 1'b1;
      tick;
      start = 1'b0;
      for (int j = 1; j < 4*TP + 2; j++) tick;
      checks++;
      assert (rd_n === 1'b0) else begin
         failures++;
         $error("FAIL mid_read_rd_n observed=%b expected=0", rd_n);
      end
      reset = 1'b1;
      tick;
      exp_rdata = 8'h00;
      check_vec("reset_in_rd_stb", expv(0, 1'b0, 8'h00, 8'h00, 8'h00));
      reset = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick;
         check_vec("post_reset_no_done", expv(0, 1'b0, 8'h00, 8'h00, 8'h00));
      end

      // T_PHASE=1 instance: 8-clock transaction, then a start the cycle after done
      for (int t = 0; t < 2; t++) begin
         addr1 = 8'h40 + 8'(t); wdata1 = 8'h99; rw1 = 1'(t); start1 = 1'b1;
         tick;
         start1 = 1'b0;
         n = 1;
         checks++;
         assert (sig_out1 === addr1 && cs_n1 === 1'b0 && wr_n1 === 1'b1 && busy1 === 1'b1)
         else begin
            failures++;
            $error("FAIL t1_addr_set observed=%h/%b/%b/%b expected=%h/0/1/1",
                   sig_out1, cs_n1, wr_n1, busy1, addr1);
         end
         while (!done1 && n < 20) begin
            tick;
            n++;
         end
         checks++;
         assert (n === 8) else begin
            failures++;
            $error("FAIL t1_latency observed=%0d expected=8", n);
         end
         tick;
         checks++;
         assert (busy1 === 1'b0 && done1 === 1'b0) else begin
            failures++;
            $error("FAIL t1_idle observed=busy%b_done%b expected=busy0_done0", busy1, done1);
         end
      end
      checks++;
      assert (rdata1 === 8'h3C) else begin
         failures++;
         $error("FAIL t1_rdata observed=%h expected=3c", rdata1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
